// File: rtl/roll_controller.sv
// rtl/roll_controller.sv - debounced push-button roll sequencer with die result capture
// Optional auto-stop of long rolls: define ROLL_CONTROLLER_AUTO_STOP_EN.
module roll_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_ROLL_CYCLES = 8,
    parameter int unsigned MAX_ROLL_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [3:0] value,
    output logic       roll,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       result_error,
    output logic       busy
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..65535");
    end
    if (MIN_ROLL_CYCLES < 1 || MIN_ROLL_CYCLES > 65535) begin : g_bad_min
        $error("MIN_ROLL_CYCLES out of range 1..65535");
    end
    if (MAX_ROLL_CYCLES < MIN_ROLL_CYCLES) begin : g_bad_max
        $error("MAX_ROLL_CYCLES must be >= MIN_ROLL_CYCLES");
    end

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] MIN_LAST = 16'(MIN_ROLL_CYCLES - 1);
`ifdef ROLL_CONTROLLER_AUTO_STOP_EN
    localparam logic [15:0] MAX_LAST = 16'(MAX_ROLL_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    logic        sync1;
    logic        sync2;
    logic        db_level;
    logic        db_rise;
    logic [15:0] db_count;

    state_t      state;
    state_t      state_next;
    logic [15:0] roll_count;
    logic        value_ok;

    // Two-flop synchronizer, then a mismatch-run counter that flips the level
    // on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_count <= 16'd0;
        end else begin
            sync1   <= button;
            sync2   <= sync1;
            db_rise <= 1'b0;
            if (sync2 == db_level) begin
                db_count <= 16'd0;
            end else if (db_count >= DEB_LAST) begin
                db_level <= ~db_level;
                db_rise  <= ~db_level;
                db_count <= 16'd0;
            end else begin
                db_count <= db_count + 16'd1;
            end
        end
    end

    assign value_ok = (value >= 4'd1) && (value <= 4'd6);

    // roll_count holds the number of completed ROLLING cycles, so comparing
    // against N-1 ends the roll after exactly N cycles of roll high.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (db_rise) begin
                    state_next = ROLLING;
                end
            end
            ROLLING: begin
                if (!db_level && (roll_count >= MIN_LAST)) begin
                    state_next = SETTLE;
                end
`ifdef ROLL_CONTROLLER_AUTO_STOP_EN
                if (roll_count >= MAX_LAST) begin
                    state_next = SETTLE;
                end
`endif
            end
            SETTLE:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            roll         <= 1'b0;
            roll_count   <= 16'd0;
            result       <= 4'd0;
            result_valid <= 1'b0;
            result_error <= 1'b0;
        end else begin
            state        <= state_next;
            roll         <= (state_next == ROLLING);
            result_valid <= (state == CAPTURE) && value_ok;
            result_error <= (state == CAPTURE) && !value_ok;
            if (state != ROLLING) begin
                roll_count <= 16'd0;
            end else if (roll_count != 16'hFFFF) begin
                roll_count <= roll_count + 16'd1;
            end
            if ((state == CAPTURE) && value_ok) begin
                result <= value;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_roll_controller.sv
// tb/tb_roll_controller.sv - randomized scoreboard bench for roll_controller
module tb_roll_controller;

    localparam int DEB  = 4;
    localparam int MINC = 8;
    localparam int MAXC = 64;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       button = 1'b0;
    logic [3:0] value  = 4'd0;
    logic       roll;
    logic [3:0] result;
    logic       result_valid;
    logic       result_error;
    logic       busy;

    roll_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .MIN_ROLL_CYCLES(MINC),
        .MAX_ROLL_CYCLES(MAXC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .button      (button),
        .value       (value),
        .roll        (roll),
        .result      (result),
        .result_valid(result_valid),
        .result_error(result_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         len;
        bit         err;
        logic [3:0] res;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] model_result = 4'd0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // A press held for h clean cycles keeps roll high max(h, MIN) cycles,
    // optionally clipped at MAX when auto-stop is built in.
    function automatic int exp_len(input int h);
        int l;
        l = (h > MINC) ? h : MINC;
`ifdef ROLL_CONTROLLER_AUTO_STOP_EN
        if (l > MAXC) l = MAXC;
`endif
        return l;
    endfunction

    task automatic push_exp(input int h, input logic [3:0] v);
        exp_t e;
        e.len = exp_len(h);
        e.err = !((v >= 4'd1) && (v <= 4'd6));
        if (!e.err) model_result = v;
        e.res = model_result;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        button = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int h, input logic [3:0] v);
        value = v;
        push_exp(h, v);
        button = 1'b1;
        repeat (h) @(posedge clock);
        #1;
        button = 1'b0;
    endtask

    task automatic glitch(input int g);
        button = 1'b1;
        repeat (g) @(posedge clock);
        #1;
        button = 1'b0;
    endtask

    int   cyc = 0;
    int   rlen = 0;
    int   fall_cyc = 0;
    bit   prev_roll = 1'b0;
    bit   waiting = 1'b0;
    exp_t cur;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            prev_roll = 1'b0;
            waiting   = 1'b0;
            rlen      = 0;
        end else begin
            if (roll) begin
                if (!prev_roll) begin
                    rlen = 1;
                    if (sb.size() == 0) check("unexpected_roll", 1, 0);
                end else begin
                    rlen++;
                end
            end else if (prev_roll && sb.size() > 0) begin
                cur = sb.pop_front();
                check("roll_len", rlen, cur.len);
                waiting  = 1'b1;
                fall_cyc = cyc;
            end
            if (result_valid || result_error) begin
                check("pulse_exclusive", int'(result_valid && result_error), 0);
                if (!waiting) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    check("pulse_latency", cyc - fall_cyc, 2);
                    check("pulse_kind_err", int'(result_error), int'(cur.err));
                    check("result", int'(result), int'(cur.res));
                    check("busy_after_capture", int'(busy), 0);
                    waiting = 1'b0;
                end
            end else if (waiting && (cyc - fall_cyc > 2)) begin
                check("missing_pulse", 1, 0);
                waiting = 1'b0;
            end
            prev_roll = roll;
        end
    end

    initial begin
        @(posedge clock);
        #1;
        check("reset_roll", int'(roll), 0);
        check("reset_result", int'(result), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(result_valid), 0);
        check("reset_error", int'(result_error), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(100);

        glitch(2);
        idle(20);

        press(20, 4'd5);
        idle(40);
        press(5, 4'd2);
        idle(40);
        press(10, 4'd7);
        idle(40);
        press(200, 4'd4);
        idle(60);
        press(6, 4'd0);
        idle(40);

        for (int i = 0; i < 25; i++) begin
            press($urandom_range(DEB, 30), 4'($urandom_range(0, 15)));
            idle($urandom_range(20, 35));
            if ($urandom_range(0, 1) == 1) glitch($urandom_range(1, DEB - 1));
            idle($urandom_range(12, 20));
        end

        // Reset in the middle of a roll, with the button kept held afterwards.
        value = 4'd3;
        push_exp(40, 4'd3);
        button = 1'b1;
        for (int i = 0; i < 50 && !roll; i++) begin
            @(posedge clock);
            #1;
        end
        check("midroll_started", int'(roll), 1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midroll_roll_drop", int'(roll), 0);
        check("midroll_busy", int'(busy), 0);
        check("midroll_result", int'(result), 0);
        sb.delete();
        model_result = 4'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_exp(12, 4'd3);
        repeat (12) @(posedge clock);
        #1;
        button = 1'b0;
        idle(40);

        for (int i = 0; i < 500 && (sb.size() != 0 || waiting); i++) @(posedge clock);
        #1;
        check("scoreboard_drained", sb.size() + int'(waiting), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
